// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state, opcode and datapath-select encodings for the multi-cycle MIPS control FSM
package mc_ctrl_pkg;
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_EX_R   = 4'd2;
  localparam logic [3:0] S_WB_R   = 4'd3;
  localparam logic [3:0] S_EX_I   = 4'd4;
  localparam logic [3:0] S_WB_I   = 4'd5;
  localparam logic [3:0] S_ADDR   = 4'd6;
  localparam logic [3:0] S_MRD    = 4'd7;
  localparam logic [3:0] S_WB_M   = 4'd8;
  localparam logic [3:0] S_MWR    = 4'd9;
  localparam logic [3:0] S_BR     = 4'd10;
  localparam logic [3:0] S_JMP    = 4'd11;
  localparam logic [3:0] S_JAL    = 4'd12;
  localparam logic [3:0] S_JR     = 4'd13;
  localparam logic [3:0] S_ERR    = 4'd15;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FN   = 2'b10;
  localparam logic [1:0] ALU_SLT  = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RS     = 2'b11;
  localparam logic [1:0] SRCB_RT  = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_BR  = 2'b11;
  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MDR = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  function automatic logic [3:0] decode_next(input logic [5:0] op, input logic [5:0] fn);
    return op == OP_RTYPE ? (fn == FN_JR ? S_JR : S_EX_R) :
           (op == OP_ADDI || op == OP_SLTI) ? S_EX_I :
           (op == OP_LW || op == OP_SW) ? S_ADDR :
           op == OP_BEQ ? S_BR :
           op == OP_J ? S_JMP :
           op == OP_JAL ? S_JAL : S_ERR;
  endfunction
endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// mc_ctrl_fsm_if: shared instruction/data memory request/ready port
interface mc_ctrl_fsm_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;
  modport master(output mem_req, output mem_we, output iord, input mem_ready);
  modport slave(input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/mc_mem_wait.sv
// mc_mem_wait: memory wait-state counter with timeout compare
module mc_mem_wait #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  input  logic ready_i,
  input  logic clear_i,
  output logic timeout_o
);
  logic [TO_W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = clear_i ? '0 : (req_i && !ready_i) ? cnt_q + TO_W'(1) : cnt_q;
    timeout_o = req_i && !ready_i && cnt_q >= TO_W'(MEM_TIMEOUT);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS-subset control sequencer; MC_CTRL_PERF_EN adds cycle/instruction counters
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  mc_ctrl_fsm_if.master mem,
  input  logic [5:0]  instr_op_i,
  input  logic [5:0]  function_i,
  input  logic        zero_i,
  output logic        ir_write_o,
  output logic        pc_write_o,
  output logic [1:0]  pc_src_o,
  output logic        alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [1:0]  alu_op_o,
  output logic        reg_write_o,
  output logic [1:0]  reg_dst_o,
  output logic [1:0]  mem_to_reg_o,
  output logic        err_o,
`ifdef MC_CTRL_PERF_EN
  output logic [31:0] cyc_cnt_o,
  output logic [31:0] instr_cnt_o,
`endif
  output logic [3:0]  state_o
);
  logic [3:0] state_q, state_d;
  logic       timeout;

  mc_mem_wait #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W)) u_wait (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .req_i(mem.mem_req),
    .ready_i(mem.mem_ready),
    .clear_i(state_d != state_q),
    .timeout_o(timeout)
  );

  always_comb begin
    state_d = state_q;
    mem.mem_req = 1'b0;
    mem.mem_we = 1'b0;
    mem.iord = 1'b0;
    ir_write_o = 1'b0;
    pc_write_o = 1'b0;
    pc_src_o = PC_ALU;
    alu_src_a_o = 1'b0;
    alu_src_b_o = SRCB_RT;
    alu_op_o = ALU_ADD;
    reg_write_o = 1'b0;
    reg_dst_o = DST_RT;
    mem_to_reg_o = WB_ALU;
    case (state_q)
      S_FETCH: begin
        mem.mem_req = 1'b1;
        alu_src_b_o = SRCB_4;
        ir_write_o = mem.mem_ready;
        pc_write_o = mem.mem_ready;
        state_d = mem.mem_ready ? S_DECODE : timeout ? S_ERR : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b_o = SRCB_BR;
        state_d = decode_next(instr_op_i, function_i);
      end
      S_EX_R: begin
        alu_src_a_o = 1'b1;
        alu_op_o = ALU_FN;
        state_d = S_WB_R;
      end
      S_WB_R: begin
        reg_write_o = 1'b1;
        reg_dst_o = DST_RD;
        state_d = S_FETCH;
      end
      S_EX_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        alu_op_o = instr_op_i == OP_SLTI ? ALU_SLT : ALU_ADD;
        state_d = S_WB_I;
      end
      S_WB_I: begin
        reg_write_o = 1'b1;
        state_d = S_FETCH;
      end
      S_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        state_d = instr_op_i == OP_SW ? S_MWR : S_MRD;
      end
      S_MRD: begin
        mem.mem_req = 1'b1;
        mem.iord = 1'b1;
        state_d = mem.mem_ready ? S_WB_M : timeout ? S_ERR : S_MRD;
      end
      S_WB_M: begin
        reg_write_o = 1'b1;
        mem_to_reg_o = WB_MDR;
        state_d = S_FETCH;
      end
      S_MWR: begin
        mem.mem_req = 1'b1;
        mem.mem_we = 1'b1;
        mem.iord = 1'b1;
        state_d = mem.mem_ready ? S_FETCH : timeout ? S_ERR : S_MWR;
      end
      S_BR: begin
        alu_src_a_o = 1'b1;
        alu_op_o = ALU_SUB;
        pc_src_o = PC_ALUOUT;
        pc_write_o = zero_i;
        state_d = S_FETCH;
      end
      S_JMP: begin
        pc_write_o = 1'b1;
        pc_src_o = PC_JUMP;
        state_d = S_FETCH;
      end
      S_JAL: begin
        pc_write_o = 1'b1;
        pc_src_o = PC_JUMP;
        reg_write_o = 1'b1;
        reg_dst_o = DST_RA;
        mem_to_reg_o = WB_PC;
        state_d = S_FETCH;
      end
      S_JR: begin
        pc_write_o = 1'b1;
        pc_src_o = PC_RS;
        state_d = S_FETCH;
      end
      default: state_d = S_ERR;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= S_FETCH;
    else state_q <= state_d;
  end

  assign err_o = state_q == S_ERR;
  assign state_o = state_q;

`ifdef MC_CTRL_PERF_EN
  logic [31:0] cyc_q, cyc_d, ins_q, ins_d;
  always_comb begin
    cyc_d = state_q != S_ERR ? cyc_q + 32'd1 : cyc_q;
    ins_d = (state_d == S_FETCH && state_q != S_FETCH) ? ins_q + 32'd1 : ins_q;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ins_q <= ins_d;
    end
  end
  assign cyc_cnt_o = cyc_q;
  assign instr_cnt_o = ins_q;
`endif
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: scoreboard bench walking every instruction class, wait states, timeout and reset
module tb_mc_ctrl_fsm;
  import mc_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst_i = 1'b0;
  logic [5:0] op = OP_RTYPE, fn = 6'b100000;
  logic zero = 1'b0;
  logic ir_write, pc_write, alu_src_a, reg_write, err;
  logic [1:0] pc_src, alu_src_b, alu_op, reg_dst, mem_to_reg;
  logic [3:0] state;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] cyc_cnt, instr_cnt;
`endif
  int n_chk = 0, n_err = 0;

  mc_ctrl_fsm_if mem();

  mc_ctrl_fsm dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .mem(mem),
    .instr_op_i(op),
    .function_i(fn),
    .zero_i(zero),
    .ir_write_o(ir_write),
    .pc_write_o(pc_write),
    .pc_src_o(pc_src),
    .alu_src_a_o(alu_src_a),
    .alu_src_b_o(alu_src_b),
    .alu_op_o(alu_op),
    .reg_write_o(reg_write),
    .reg_dst_o(reg_dst),
    .mem_to_reg_o(mem_to_reg),
    .err_o(err),
`ifdef MC_CTRL_PERF_EN
    .cyc_cnt_o(cyc_cnt),
    .instr_cnt_o(instr_cnt),
`endif
    .state_o(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic [18:0] v;
  } exp_t;
  exp_t sb[$];
  string tq[$];
  logic [18:0] got_v;
  assign got_v = {mem.mem_req, mem.mem_we, mem.iord, ir_write, pc_write, pc_src, alu_src_a,
                  alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, err};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [18:0] exp_out(input logic [3:0] st, input logic [5:0] o, input logic rdy, input logic z);
    logic req = 0, we = 0, io = 0, irw = 0, pcw = 0, sa = 0, rw = 0, e = 0;
    logic [1:0] ps = 0, sbv = 0, ao = 0, rd = 0, mr = 0;
    case (st)
      4'd0:  begin req = 1; sbv = 2'b01; irw = rdy; pcw = rdy; end
      4'd1:  sbv = 2'b11;
      4'd2:  begin sa = 1; ao = 2'b10; end
      4'd3:  begin rw = 1; rd = 2'b01; end
      4'd4:  begin sa = 1; sbv = 2'b10; ao = (o == 6'b001010) ? 2'b11 : 2'b00; end
      4'd5:  rw = 1;
      4'd6:  begin sa = 1; sbv = 2'b10; end
      4'd7:  begin req = 1; io = 1; end
      4'd8:  begin rw = 1; mr = 2'b01; end
      4'd9:  begin req = 1; we = 1; io = 1; end
      4'd10: begin sa = 1; ao = 2'b01; ps = 2'b01; pcw = z; end
      4'd11: begin pcw = 1; ps = 2'b10; end
      4'd12: begin pcw = 1; ps = 2'b10; rw = 1; rd = 2'b10; mr = 2'b10; end
      4'd13: begin pcw = 1; ps = 2'b11; end
      default: e = 1;
    endcase
    return {req, we, io, irw, pcw, ps, sa, sbv, ao, rw, rd, mr, e};
  endfunction

  // One cycle: drive inputs for the cycle in which the DUT should sit in state st.
  task automatic step(input string tag, input logic [3:0] st, input logic rdy = 1'b1,
                      input logic z = 1'b0, input logic rn = 1'b1);
    @(negedge clk);
    rst_i = rn;
    mem.mem_ready = rdy;
    zero = z;
    sb.push_back('{st: st, v: exp_out(st, op, rdy, z)});
    tq.push_back(tag);
    #2;
  endtask

  always @(negedge clk) begin
    exp_t e;
    string t;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      t = tq.pop_front();
      chk({t, "/state"}, 32'(state), 32'(e.st));
      chk({t, "/outs"}, 32'(got_v), 32'(e.v));
    end
  end

  task automatic run3(input string tag, input logic [5:0] o, input logic [5:0] f,
                      input logic [3:0] s2, input logic z = 1'b0);
    op = o;
    fn = f;
    step({tag, "_f"}, S_FETCH);
    step({tag, "_d"}, S_DECODE);
    step({tag, "_x"}, s2, 1'b1, z);
  endtask

  initial begin
    mem.mem_ready = 1'b0;
    step("rst0", S_FETCH, 1'b0, 1'b0, 1'b0);
    step("rst1", S_FETCH, 1'b0, 1'b0, 1'b0);
    run3("add", OP_RTYPE, 6'b100000, S_EX_R);
    step("add_wb", S_WB_R);
    op = OP_LW;
    for (int i = 0; i < 3; i++) step("lw_fw", S_FETCH, 1'b0);
    step("lw_f", S_FETCH);
    step("lw_d", S_DECODE);
    step("lw_a", S_ADDR);
    for (int i = 0; i < 2; i++) step("lw_mw", S_MRD, 1'b0);
    step("lw_m", S_MRD);
    step("lw_wb", S_WB_M);
    run3("sw", OP_SW, 6'd0, S_ADDR);
    step("sw_m", S_MWR);
    run3("addi", OP_ADDI, 6'd0, S_EX_I);
    step("addi_wb", S_WB_I);
    run3("slti", OP_SLTI, 6'd0, S_EX_I);
    step("slti_wb", S_WB_I);
    run3("beq0", OP_BEQ, 6'd0, S_BR, 1'b0);
    run3("beq1", OP_BEQ, 6'd0, S_BR, 1'b1);
    run3("j", OP_J, 6'd0, S_JMP);
    run3("jal", OP_JAL, 6'd0, S_JAL);
    run3("jr", OP_RTYPE, FN_JR, S_JR);
    op = OP_J;
    for (int i = 0; i < 16; i++) step("edge_w", S_FETCH, 1'b0);
    step("edge_rdy", S_FETCH);
    step("edge_d", S_DECODE);
    step("edge_j", S_JMP);
    op = OP_LW;
    fn = 6'd0;
    step("abrt_f", S_FETCH);
    step("abrt_d", S_DECODE);
    step("abrt_a", S_ADDR);
    step("abrt_mw", S_MRD, 1'b0);
    step("abrt_rst", S_MRD, 1'b0, 1'b0, 1'b0);
    op = OP_RTYPE;
    fn = 6'b100000;
    step("abrt_post", S_FETCH, 1'b0);
    step("abrt_f2", S_FETCH);
    step("abrt_d2", S_DECODE);
    step("abrt_x", S_EX_R);
    step("abrt_wb", S_WB_R);
    run3("ill", 6'b111111, 6'd0, S_ERR);
    step("ill_hold", S_ERR);
    step("ill_hold2", S_ERR, 1'b0);
    step("ill_rst", S_ERR, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) step("to_w", S_FETCH, 1'b0);
    step("to_err", S_ERR, 1'b0);
    step("to_hold", S_ERR);
    step("to_rst", S_ERR, 1'b1, 1'b0, 1'b0);
    run3("fin", OP_RTYPE, 6'b100010, S_EX_R);
    step("fin_wb", S_WB_R);
    @(negedge clk);
    #3;
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
